// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared constants, state encoding and line-address helper for
//               the cache refill path.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int unsigned C_LINE_WORDS = 4;
    localparam int unsigned C_WIDX_W     = $clog2(C_LINE_WORDS);

    localparam int unsigned      C_ST_W    = 3;
    localparam logic [C_ST_W-1:0] C_ST_IDLE = 3'd0;
    localparam logic [C_ST_W-1:0] C_ST_REQ  = 3'd1;
    localparam logic [C_ST_W-1:0] C_ST_FILL = 3'd2;
    localparam logic [C_ST_W-1:0] C_ST_TAG  = 3'd3;
    localparam logic [C_ST_W-1:0] C_ST_DONE = 3'd4;

    typedef enum logic [C_ST_W-1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_REQ  = C_ST_REQ,
        ST_FILL = C_ST_FILL,
        ST_TAG  = C_ST_TAG,
        ST_DONE = C_ST_DONE
    } state_t;

    // All-ones mask with the low off_bits cleared; AND with an address to get its line base.
    function automatic logic [63:0] line_base_mask(input int unsigned off_bits);
        logic [63:0] v_offset_mask;
        v_offset_mask = (64'd1 << off_bits) - 64'd1;
        return ~v_offset_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/refill_word_counter.sv
`default_nettype none
// ============================================================================
// Module      : refill_word_counter
// Description : Word-index counter for line transfers with clear, increment
//               and last-word flag; wraps to zero after the last word.
// Revision    : 1.0 - initial release
// ============================================================================
module refill_word_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_last
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = &r_cnt;

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Cache miss handler: stalls the CPU, fetches a whole line over
//               a req/ack burst, writes data and tag arrays, then releases.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = C_LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cache_enable,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic                          tag_hit,
    output logic                          cache_busy_n,
    output logic                          rd_valid,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ack,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_err,
    output logic                          data_we,
    output logic [$clog2(LINE_WORDS)-1:0] data_widx,
    output logic [DATA_W-1:0]             data_wdata,
    output logic                          tag_we,
    output logic                          refill_err
);

    localparam int WIDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = $clog2(LINE_WORDS * DATA_W / 8);
    localparam logic [ADDR_W-1:0] C_BASE_MASK = ADDR_W'(line_base_mask(OFF_W));

    state_t r_state;
    state_t w_next_state;

    logic              w_hit_pulse;
    logic              w_miss;
    logic              w_word;
    logic              w_abort;
    logic [WIDX_W-1:0] w_cnt;
    logic              w_cnt_last;

    logic              r_busy_n;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_data_we;
    logic [WIDX_W-1:0] r_data_widx;
    logic [DATA_W-1:0] r_data_wdata;
    logic              r_refill_err;

    refill_word_counter #(
        .WIDTH (WIDX_W)
    ) u_word_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_miss | w_abort),
        .i_inc  (w_word),
        .o_cnt  (w_cnt),
        .o_last (w_cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_hit_pulse  = 1'b0;
        w_miss       = 1'b0;
        w_word       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cache_enable) begin
                    if (tag_hit) begin
                        w_hit_pulse = 1'b1;
                    end else begin
                        w_miss       = 1'b1;
                        w_next_state = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Error wins over a same-cycle ack; a word arriving with the ack is word 0.
                if (mem_err) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_DONE;
                end else if (mem_ack) begin
                    w_word       = mem_rvalid;
                    w_next_state = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_err) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_DONE;
                end else if (mem_rvalid) begin
                    w_word = 1'b1;
                    if (w_cnt_last) begin
                        w_next_state = ST_TAG;
                    end
                end
            end
            ST_TAG:  w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_n     <= 1'b1;
            r_rd_valid   <= 1'b0;
            r_mem_addr   <= '0;
            r_data_we    <= 1'b0;
            r_data_widx  <= '0;
            r_data_wdata <= '0;
            r_refill_err <= 1'b0;
        end else begin
            r_rd_valid   <= w_hit_pulse;
            r_data_we    <= w_word;
            r_refill_err <= w_abort;
            if (w_word) begin
                r_data_widx  <= w_cnt;
                r_data_wdata <= mem_rdata;
            end
            if (w_miss) begin
                r_mem_addr <= cpu_addr & C_BASE_MASK;
                r_busy_n   <= 1'b0;
            end else if (w_next_state == ST_DONE) begin
                r_busy_n <= 1'b1;
            end
        end
    end

    assign cache_busy_n = r_busy_n;
    assign rd_valid     = r_rd_valid;
    assign mem_req      = (r_state == ST_REQ);
    assign mem_addr     = r_mem_addr;
    assign data_we      = r_data_we;
    assign data_widx    = r_data_widx;
    assign data_wdata   = r_data_wdata;
    assign tag_we       = (r_state == ST_TAG);
    assign refill_err   = r_refill_err;

endmodule
`default_nettype wire
